// File: rtl/a2rt_pkg.sv
// Shared types and constants for the a2rt pixel source: pattern modes,
// controller states and the colour-bar palette.
package a2rt_pkg;

   // Pattern selection, sampled at every frame start
   typedef enum logic [1:0] {
      MODE_SOLID = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_RAMP  = 2'd2,
      MODE_CHECK = 2'd3
   } mode_e;

   // Frame controller states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } state_e;

   localparam int NUM_BARS = 8;

   // Colour-bar palette, RGB with R in the top byte
   localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
   localparam logic [23:0] COL_GREEN   = 24'h00FF00;
   localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] COL_RED     = 24'hFF0000;
   localparam logic [23:0] COL_BLUE    = 24'h0000FF;
   localparam logic [23:0] COL_BLACK   = 24'h000000;

   // Bar index (left to right) to colour
   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] col;
      case (idx)
         3'd0:    col = COL_WHITE;
         3'd1:    col = COL_YELLOW;
         3'd2:    col = COL_CYAN;
         3'd3:    col = COL_GREEN;
         3'd4:    col = COL_MAGENTA;
         3'd5:    col = COL_RED;
         3'd6:    col = COL_BLUE;
         default: col = COL_BLACK;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/a2rt_pattern.sv
// Combinational test-pattern generator: maps (mode, x, y, solid) to a pixel.
module a2rt_pattern
   import a2rt_pkg::*;
#(
   parameter int DATA_WIDTH   = 24,
   parameter int SCREEN_WIDTH = 800,
   parameter int XW           = 10,
   parameter int YW           = 10
)(
   input  mode_e                 i_mode,
   input  logic [XW-1:0]         i_x,
   input  logic [YW-1:0]         i_y,
   input  logic [DATA_WIDTH-1:0] i_solid,
   output logic [DATA_WIDTH-1:0] o_pixel
);

   // Integer bar width; the last bar takes whatever remainder is left
   localparam int BAR_W = SCREEN_WIDTH / NUM_BARS;

   logic [NUM_BARS-2:0] w_past_edge;
   logic [2:0]          w_bar_idx;
   logic [7:0]          w_gray;
   logic                w_check;

   // One comparator per internal bar edge; together they form a thermometer code
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BARS - 1; gi++) begin : g_bar_edge
         assign w_past_edge[gi] = (i_x >= XW'((gi + 1) * BAR_W));
      end
   endgenerate

   // Bar index is the number of edges already passed (saturates at the last bar)
   always_comb begin
      w_bar_idx = '0;
      for (int i = 0; i < NUM_BARS - 1; i++) begin
         w_bar_idx = w_bar_idx + 3'(w_past_edge[i]);
      end
   end

   assign w_gray  = 8'(i_x);
   assign w_check = 1'(i_x >> 3) ^ 1'(i_y >> 4);

   // Pattern select
   always_comb begin
      o_pixel = '0;
      case (i_mode)
         MODE_SOLID: o_pixel = i_solid;
         MODE_BARS:  o_pixel = DATA_WIDTH'(bar_colour(w_bar_idx));
         MODE_RAMP:  o_pixel = DATA_WIDTH'({3{w_gray}});
         MODE_CHECK: o_pixel = w_check ? DATA_WIDTH'(COL_WHITE) : DATA_WIDTH'(COL_BLACK);
         default:    o_pixel = '0;
      endcase
   end

endmodule

// File: rtl/a2rt_pix_src.sv
// Test-pattern pixel source with rts/rtr handshake: single frame or
// continuous frames separated by a fixed idle gap.
module a2rt_pix_src
   import a2rt_pkg::*;
#(
   parameter int DATA_WIDTH    = 24,
   parameter int SCREEN_WIDTH  = 800,
   parameter int SCREEN_HEIGHT = 600,
   parameter int GAP_CYCLES    = 16
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  continuous_i,
   input  logic                  stop_i,
   input  logic [1:0]            mode_i,
   input  logic [DATA_WIDTH-1:0] solid_i,
   input  logic                  rtr_i,
   output logic                  rts_o,
   output logic                  eow_o,
   output logic                  sof_o,
   output logic [DATA_WIDTH-1:0] pixel_o,
   output logic                  busy_o,
   output logic                  frame_done_o
);

   localparam int XW = (SCREEN_WIDTH > 1)  ? $clog2(SCREEN_WIDTH)  : 1;
   localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [XW-1:0] X_LAST   = XW'(SCREEN_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(SCREEN_HEIGHT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   state_e                r_state, w_state_next;
   logic [XW-1:0]         r_x, w_x_next;
   logic [YW-1:0]         r_y, w_y_next;
   mode_e                 r_mode, w_mode_next;
   logic [DATA_WIDTH-1:0] r_solid, w_solid_next;
   logic                  r_cont;
   logic                  r_stop_req;
   logic [GW-1:0]         r_gap_cnt;
   logic                  r_rts, r_eow, r_sof, r_done;
   logic [DATA_WIDTH-1:0] r_pixel;

   logic                  w_xfer, w_last_pix, w_frame_end, w_advance;
   logic                  w_stop_pend, w_gap_end, w_frame_start;
   logic [DATA_WIDTH-1:0] w_pixel;

   // r_x/r_y always hold the coordinate of the pixel currently presented
   assign w_xfer      = r_rts & rtr_i;
   assign w_last_pix  = (r_x == X_LAST) && (r_y == Y_LAST);
   assign w_frame_end = w_xfer & w_last_pix;
   assign w_advance   = w_xfer & ~w_last_pix;
   assign w_stop_pend = r_stop_req | stop_i;
   assign w_gap_end   = (r_gap_cnt == GAP_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; start_i is only looked at in IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start_i) w_state_next = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (w_frame_end) w_state_next = (r_cont && !w_stop_pend) ? ST_GAP : ST_IDLE;
         end
         ST_GAP: begin
            if (w_stop_pend)    w_state_next = ST_IDLE;
            else if (w_gap_end) w_state_next = ST_ACTIVE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Output logic: frame-start detection and next coordinate / pattern inputs
   always_comb begin
      w_frame_start = 1'b0;
      case (r_state)
         ST_IDLE: w_frame_start = start_i;
         ST_GAP:  w_frame_start = !w_stop_pend && w_gap_end;
         default: w_frame_start = 1'b0;
      endcase

      w_x_next     = r_x;
      w_y_next     = r_y;
      w_mode_next  = r_mode;
      w_solid_next = r_solid;
      if (w_frame_start) begin
         w_x_next     = '0;
         w_y_next     = '0;
         w_mode_next  = mode_e'(mode_i);
         w_solid_next = solid_i;
      end else if (w_advance) begin
         if (r_x == X_LAST) begin
            w_x_next = '0;
            w_y_next = r_y + YW'(1);
         end else begin
            w_x_next = r_x + XW'(1);
         end
      end
   end

   // Pixel for the coordinate about to be presented
   a2rt_pattern #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SCREEN_WIDTH (SCREEN_WIDTH),
      .XW           (XW),
      .YW           (YW)
   ) u_pattern (
      .i_mode  (w_mode_next),
      .i_x     (w_x_next),
      .i_y     (w_y_next),
      .i_solid (w_solid_next),
      .o_pixel (w_pixel)
   );

   // Coordinate counters and per-frame latched settings
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x     <= '0;
         r_y     <= '0;
         r_mode  <= MODE_SOLID;
         r_solid <= '0;
         r_cont  <= 1'b0;
      end else begin
         r_x     <= w_x_next;
         r_y     <= w_y_next;
         r_mode  <= w_mode_next;
         r_solid <= w_solid_next;
         if (r_state == ST_IDLE && start_i) r_cont <= continuous_i;
      end
   end

   // Registered stream outputs; they only change on a load, so a stall holds them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rts   <= 1'b0;
         r_eow   <= 1'b0;
         r_sof   <= 1'b0;
         r_pixel <= '0;
         r_done  <= 1'b0;
      end else begin
         if (w_frame_start || w_advance) begin
            r_rts   <= 1'b1;
            r_pixel <= w_pixel;
            r_eow   <= (w_x_next == X_LAST);
            r_sof   <= w_frame_start;
         end else if (w_frame_end) begin
            r_rts <= 1'b0;
            r_eow <= 1'b0;
            r_sof <= 1'b0;
         end
         r_done <= w_frame_end;
      end
   end

   // Gap timer and sticky stop request (cleared whenever IDLE is entered)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap_cnt  <= '0;
         r_stop_req <= 1'b0;
      end else begin
         r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GW'(1) : '0;
         if (w_state_next == ST_IDLE)             r_stop_req <= 1'b0;
         else if (r_state != ST_IDLE && stop_i)   r_stop_req <= 1'b1;
      end
   end

   assign rts_o        = r_rts;
   assign eow_o        = r_eow;
   assign sof_o        = r_sof;
   assign pixel_o      = r_pixel;
   assign frame_done_o = r_done;
   assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_a2rt_pix_src.sv
// Directed bench for a2rt_pix_src: a wide/short instance for solid, bars,
// ramp, continuous and reset scenarios, and a 16x32 instance for the checker.
module tb_a2rt_pix_src;

   localparam int AW = 800;
   localparam int AH = 4;
   localparam int AG = 16;
   localparam int BW = 16;
   localparam int BH = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        a_start = 0, a_cont = 0, a_stop = 0, a_rtr = 1;
   logic [1:0]  a_mode = 0;
   logic [23:0] a_solid = 0;
   logic        a_rts, a_eow, a_sof, a_busy, a_done;
   logic [23:0] a_pix;

   logic        b_start = 0, b_cont = 0, b_stop = 0, b_rtr = 1;
   logic [1:0]  b_mode = 0;
   logic [23:0] b_solid = 0;
   logic        b_rts, b_eow, b_sof, b_busy, b_done;
   logic [23:0] b_pix;

   int n_checks = 0;
   int n_errors = 0;

   // Monitor state for instance A
   int          ax = 0, ay = 0;
   int          a_xfers = 0, a_eows = 0, a_sofs = 0, a_dones = 0;
   int          a_gap_run = 0, a_last_gap = -1;
   int          a_cur_mode = 0;
   logic [23:0] a_cur_solid = 0;
   logic        a_prev_stall = 0, a_prev_eow = 0, a_prev_sof = 0;
   logic [23:0] a_prev_pix = 0;
   logic        a_rand = 0;

   // Monitor state for instance B
   int          bx = 0, by = 0;
   int          b_xfers = 0, b_eows = 0, b_dones = 0;
   logic [23:0] b_p00 = 24'h5A5A5A, b_p80 = 24'h5A5A5A, b_p016 = 24'h5A5A5A, b_p816 = 24'h5A5A5A;

   always #5 clk = ~clk;

   a2rt_pix_src #(
      .DATA_WIDTH(24), .SCREEN_WIDTH(AW), .SCREEN_HEIGHT(AH), .GAP_CYCLES(AG)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start_i(a_start), .continuous_i(a_cont),
      .stop_i(a_stop), .mode_i(a_mode), .solid_i(a_solid), .rtr_i(a_rtr),
      .rts_o(a_rts), .eow_o(a_eow), .sof_o(a_sof), .pixel_o(a_pix),
      .busy_o(a_busy), .frame_done_o(a_done)
   );

   a2rt_pix_src #(
      .DATA_WIDTH(24), .SCREEN_WIDTH(BW), .SCREEN_HEIGHT(BH), .GAP_CYCLES(4)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start_i(b_start), .continuous_i(b_cont),
      .stop_i(b_stop), .mode_i(b_mode), .solid_i(b_solid), .rtr_i(b_rtr),
      .rts_o(b_rts), .eow_o(b_eow), .sof_o(b_sof), .pixel_o(b_pix),
      .busy_o(b_busy), .frame_done_o(b_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference pattern for a screen of width w
   function automatic logic [23:0] model_pix(input int mode, input logic [23:0] solid,
                                             input int x, input int y, input int w);
      logic [23:0] res;
      logic [7:0]  g;
      int          idx;
      res = 24'h0;
      case (mode)
         0: res = solid;
         1: begin
            idx = x / (w / 8);
            if (idx > 7) idx = 7;
            case (idx)
               0: res = 24'hFFFFFF;
               1: res = 24'hFFFF00;
               2: res = 24'h00FFFF;
               3: res = 24'h00FF00;
               4: res = 24'hFF00FF;
               5: res = 24'hFF0000;
               6: res = 24'h0000FF;
               default: res = 24'h000000;
            endcase
         end
         2: begin
            g = x[7:0];
            res = {g, g, g};
         end
         default: res = ((((x >> 3) ^ (y >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      endcase
      return res;
   endfunction

   // Ready driver for A: constant or random per cycle
   initial begin
      forever begin
         @(posedge clk);
         #1;
         a_rtr = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor A: handshake, framing, pixel values, stall stability, gap length
   always @(negedge clk) begin
      if (!rst_n) begin
         ax = 0; ay = 0; a_prev_stall = 0; a_gap_run = 0;
      end else begin
         if (a_prev_stall) begin
            chk("a_hold_rts", a_rts, 1);
            chk("a_hold_pix", a_pix, a_prev_pix);
            chk("a_hold_eow", a_eow, a_prev_eow);
            chk("a_hold_sof", a_sof, a_prev_sof);
         end
         if (ax != 0 || ay != 0) chk("a_no_bubble", a_rts, 1);
         if (a_done) a_dones++;
         if (a_rts) begin
            if (a_gap_run > 0) a_last_gap = a_gap_run;
            a_gap_run = 0;
         end else if (a_busy) begin
            a_gap_run++;
         end else begin
            a_gap_run = 0;
         end
         if (a_rts && a_rtr) begin
            if (ax == 0 && ay == 0) begin
               a_cur_mode  = a_mode;
               a_cur_solid = a_solid;
            end
            chk("a_sof", a_sof, (ax == 0 && ay == 0));
            chk("a_eow", a_eow, (ax == AW - 1));
            chk("a_pix", a_pix, model_pix(a_cur_mode, a_cur_solid, ax, ay, AW));
            if (a_cur_mode == 1 && ay == 0) begin
               case (ax)
                  0:   chk("bar_x0",   a_pix, 24'hFFFFFF);
                  99:  chk("bar_x99",  a_pix, 24'hFFFFFF);
                  100: chk("bar_x100", a_pix, 24'hFFFF00);
                  700: chk("bar_x700", a_pix, 24'h000000);
                  799: chk("bar_x799", a_pix, 24'h000000);
                  default: ;
               endcase
            end
            a_xfers++;
            if (a_eow) a_eows++;
            if (a_sof) a_sofs++;
            if (ax == AW - 1) begin
               ax = 0;
               ay = (ay == AH - 1) ? 0 : ay + 1;
            end else begin
               ax++;
            end
         end
         a_prev_stall = a_rts && !a_rtr;
         a_prev_pix   = a_pix;
         a_prev_eow   = a_eow;
         a_prev_sof   = a_sof;
      end
   end

   // Monitor B: checker pattern on the small screen
   always @(negedge clk) begin
      if (!rst_n) begin
         bx = 0; by = 0;
      end else begin
         if (b_done) b_dones++;
         if (b_rts && b_rtr) begin
            chk("b_pix", b_pix, model_pix(3, 24'h0, bx, by, BW));
            if (bx == 0 && by == 0)  b_p00  = b_pix;
            if (bx == 8 && by == 0)  b_p80  = b_pix;
            if (bx == 0 && by == 16) b_p016 = b_pix;
            if (bx == 8 && by == 16) b_p816 = b_pix;
            b_xfers++;
            if (b_eow) b_eows++;
            if (bx == BW - 1) begin
               bx = 0;
               by = (by == BH - 1) ? 0 : by + 1;
            end else begin
               bx++;
            end
         end
      end
   end

   task automatic clr_a();
      a_xfers = 0; a_eows = 0; a_sofs = 0; a_dones = 0; a_last_gap = -1;
   endtask

   task automatic start_a(input logic [1:0] mode, input logic [23:0] solid,
                          input logic cont, input logic [23:0] first_pix);
      @(posedge clk); #1;
      a_mode = mode; a_solid = solid; a_cont = cont; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      @(negedge clk);
      chk("a_first_rts", a_rts, 1);
      chk("a_first_sof", a_sof, 1);
      chk("a_first_pix", a_pix, first_pix);
   endtask

   task automatic wait_done_a(input int target, input int budget);
      int k;
      k = 0;
      while (a_dones < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("a_done_wait", a_dones, target);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rts", a_rts, 0);   chk("rst_eow", a_eow, 0);
      chk("rst_sof", a_sof, 0);   chk("rst_pix", a_pix, 0);
      chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_rts", a_rts, 0);
      chk("idle_busy", a_busy, 0);
      chk("idle_done_cnt", a_dones, 0);
      $display("[%0t] reset: outputs quiet", $time);

      // Solid frame at full rate; a start pulse mid-frame must be ignored
      clr_a();
      start_a(2'd0, 24'h123456, 1'b0, 24'h123456);
      repeat (500) @(posedge clk);
      #1; a_mode = 2'd3; a_solid = 24'h000000; a_start = 1'b1;
      @(posedge clk); #1; a_start = 1'b0;
      wait_done_a(1, 5000);
      repeat (20) @(negedge clk);
      chk("solid_xfers", a_xfers, AW * AH);
      chk("solid_eows", a_eows, AH);
      chk("solid_sofs", a_sofs, 1);
      chk("solid_dones", a_dones, 1);
      chk("solid_idle", a_busy, 0);
      $display("[%0t] frame mode0: xfers=%0d eow=%0d sof=%0d done=%0d", $time, a_xfers, a_eows, a_sofs, a_dones);

      // Colour bars with random back-pressure
      clr_a();
      a_rand = 1'b1;
      start_a(2'd1, 24'h0, 1'b0, 24'hFFFFFF);
      wait_done_a(1, 30000);
      a_rand = 1'b0;
      repeat (10) @(negedge clk);
      chk("bars_xfers", a_xfers, AW * AH);
      chk("bars_eows", a_eows, AH);
      chk("bars_idle", a_busy, 0);
      $display("[%0t] frame mode1 stalled: xfers=%0d eow=%0d", $time, a_xfers, a_eows);

      // Gray ramp
      clr_a();
      start_a(2'd2, 24'h0, 1'b0, 24'h000000);
      wait_done_a(1, 5000);
      repeat (5) @(negedge clk);
      chk("ramp_xfers", a_xfers, AW * AH);
      $display("[%0t] frame mode2: xfers=%0d", $time, a_xfers);

      // Continuous: mode changes during frame 1, stop pulsed mid frame 2
      clr_a();
      start_a(2'd0, 24'h111111, 1'b1, 24'h111111);
      repeat (50) @(posedge clk);
      #1; a_mode = 2'd2;
      wait_done_a(1, 5000);
      begin
         int k;
         k = 0;
         while (a_sofs < 2 && k < 200) begin
            @(negedge clk);
            k++;
         end
      end
      chk("cont_second_sof", a_sofs, 2);
      chk("cont_gap_len", a_last_gap, AG);
      repeat (100) @(posedge clk);
      #1; a_stop = 1'b1;
      @(posedge clk); #1; a_stop = 1'b0;
      wait_done_a(2, 5000);
      repeat (40) @(negedge clk);
      chk("cont_dones", a_dones, 2);
      chk("cont_sofs", a_sofs, 2);
      chk("cont_xfers", a_xfers, 2 * AW * AH);
      chk("cont_eows", a_eows, 2 * AH);
      chk("cont_idle", a_busy, 0);
      $display("[%0t] continuous: frames=%0d gap=%0d xfers=%0d", $time, a_dones, a_last_gap, a_xfers);

      // Reset asserted while pixel (5,3) is presented
      clr_a();
      start_a(2'd2, 24'h0, 1'b0, 24'h000000);
      begin
         int k;
         k = 0;
         while (!(ax == 5 && ay == 3) && k < 5000) begin
            @(posedge clk); #1;
            k++;
         end
      end
      chk("pos_y", ay, 3);
      chk("pos_pix", a_pix, 24'h050505);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rts", a_rts, 0);   chk("mid_rst_eow", a_eow, 0);
      chk("mid_rst_sof", a_sof, 0);   chk("mid_rst_pix", a_pix, 0);
      chk("mid_rst_busy", a_busy, 0); chk("mid_rst_done", a_done, 0);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_rts", a_rts, 0);
      clr_a();
      start_a(2'd0, 24'hABCDEF, 1'b0, 24'hABCDEF);
      wait_done_a(1, 5000);
      repeat (5) @(negedge clk);
      chk("restart_xfers", a_xfers, AW * AH);
      chk("restart_sofs", a_sofs, 1);
      $display("[%0t] reset mid-frame: restart xfers=%0d", $time, a_xfers);

      // Checker on the 16x32 instance
      @(posedge clk); #1;
      b_mode = 2'd3; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      begin
         int k;
         k = 0;
         while (b_dones < 1 && k < 2000) begin
            @(negedge clk);
            k++;
         end
      end
      repeat (5) @(negedge clk);
      chk("chk_p00", b_p00, 24'h000000);
      chk("chk_p80", b_p80, 24'hFFFFFF);
      chk("chk_p016", b_p016, 24'hFFFFFF);
      chk("chk_p816", b_p816, 24'h000000);
      chk("chk_xfers", b_xfers, BW * BH);
      chk("chk_eows", b_eows, BH);
      chk("chk_dones", b_dones, 1);
      chk("chk_idle", b_busy, 0);
      $display("[%0t] frame mode3 16x32: xfers=%0d eow=%0d", $time, b_xfers, b_eows);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
